// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// The result is computed at acceptance and parked in a pending register; a
// down-counter models the latency and commits {hi,lo} on its last tick.
module mult_div_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_RSVD  = 3'd7
   } md_op_e;

   localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

   logic [3:0]  cnt_q, cnt_d;
   logic [63:0] pend_q, pend_d;
   logic        nowr_q, nowr_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic               div_ovf;
   logic        [31:0] b_safe;
   logic signed [31:0] quo_s, rem_s;
   logic        [31:0] quo_u, rem_u;
   md_op_e             op_e;

   assign op_e = md_op_e'(op);

   // Full-width products; operands are extended to 64 bits so nothing is lost.
   assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign prod_u = {32'd0, a} * {32'd0, b};

   // Divisor is forced to 1 for b==0 (result discarded anyway) and for
   // INT_MIN / -1, where a/1 already yields the wanted LO=0x80000000, HI=0
   // without ever evaluating the overflowing signed division.
   assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
   assign b_safe  = ((b == 32'd0) || div_ovf) ? 32'd1 : b;
   assign quo_s   = $signed(a) / $signed(b_safe);
   assign rem_s   = $signed(a) % $signed(b_safe);
   assign quo_u   = a / b_safe;
   assign rem_u   = a % b_safe;

   // Acceptance when idle, countdown and commit when busy.
   always_comb begin
      cnt_d  = cnt_q;
      pend_d = pend_q;
      nowr_d = nowr_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      if (cnt_q == 4'd0) begin
         case (op_e)
            OP_MULT: begin
               pend_d = prod_s;
               nowr_d = 1'b0;
               cnt_d  = MULT_CNT;
            end
            OP_MULTU: begin
               pend_d = prod_u;
               nowr_d = 1'b0;
               cnt_d  = MULT_CNT;
            end
            OP_DIV: begin
               pend_d = {rem_s, quo_s};
               nowr_d = (b == 32'd0);
               cnt_d  = DIV_CNT;
            end
            OP_DIVU: begin
               pend_d = {rem_u, quo_u};
               nowr_d = (b == 32'd0);
               cnt_d  = DIV_CNT;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
         endcase
      end else begin
         cnt_d = cnt_q - 4'd1;
         if ((cnt_q == 4'd1) && !nowr_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
         end
      end
   end

   // State registers; reset discards any in-flight result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= 4'd0;
         pend_q <= 64'd0;
         nowr_q <= 1'b0;
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
      end else begin
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
         nowr_q <= nowr_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
      end
   end

   assign busy = (cnt_q != 4'd0);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus randomized bench for mult_div_unit with a plain-arithmetic
// reference model of HI/LO.
module tb_mult_div_unit;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy;
   logic [31:0] hi, lo;

   int tests = 0;
   int fails = 0;

   logic [31:0] hi_m = 32'd0;
   logic [31:0] lo_m = 32'd0;

   mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference result of an MD op: returns whether HI/LO get written and the values.
   task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output bit wr, output logic [31:0] h, output logic [31:0] l);
      int          sx, sy;
      longint      p, q, r;
      logic [63:0] pu;
      sx = x;
      sy = y;
      wr = 1'b1;
      h  = hi_m;
      l  = lo_m;
      case (o)
         3'd1: begin
            p = longint'(sx) * longint'(sy);
            pu = p;
            h = pu[63:32];
            l = pu[31:0];
         end
         3'd2: begin
            pu = {32'd0, x} * {32'd0, y};
            h = pu[63:32];
            l = pu[31:0];
         end
         3'd3, 3'd4: begin
            if (y == 32'd0) wr = 1'b0;
            else begin
               if (o == 3'd3) begin
                  q = longint'(sx) / longint'(sy);
                  r = longint'(sx) % longint'(sy);
               end else begin
                  q = longint'({32'd0, x}) / longint'({32'd0, y});
                  r = longint'({32'd0, x}) % longint'({32'd0, y});
               end
               pu = q;
               l = pu[31:0];
               pu = r;
               h = pu[31:0];
            end
         end
         default: wr = 1'b0;
      endcase
   endtask

   // Issue a mult/div, check busy width and HI/LO stability, then the result.
   task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      bit          wr;
      logic [31:0] h, l;
      int          n;
      n = (o <= 3'd2) ? MC : DC;
      model(o, x, y, wr, h, l);
      op = o; a = x; b = y;
      @(negedge clk);
      op = 3'd0; a = $urandom; b = $urandom;
      for (int i = 0; i < n; i++) begin
         chk({tag, " busy"}, {31'd0, busy}, 32'd1);
         chk({tag, " hi hold"}, hi, hi_m);
         chk({tag, " lo hold"}, lo, lo_m);
         @(negedge clk);
      end
      if (wr) begin
         hi_m = h;
         lo_m = l;
      end
      chk({tag, " busy end"}, {31'd0, busy}, 32'd0);
      chk({tag, " hi"}, hi, hi_m);
      chk({tag, " lo"}, lo, lo_m);
   endtask

   task automatic run_mt(input string tag, input logic [2:0] o, input logic [31:0] x);
      op = o; a = x;
      @(negedge clk);
      op = 3'd0;
      if (o == 3'd5) hi_m = x; else lo_m = x;
      chk({tag, " busy"}, {31'd0, busy}, 32'd0);
      chk({tag, " hi"}, hi, hi_m);
      chk({tag, " lo"}, lo, lo_m);
   endtask

   initial begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;

      reset = 1'b1; op = 3'd0; a = 32'd0; b = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst busy", {31'd0, busy}, 32'd0);
         chk("rst hi", hi, 32'd0);
         chk("rst lo", lo, 32'd0);
      end

      run_md("mult neg", 3'd1, 32'hFFFF_FFFD, 32'd5);
      chk("mult neg hi const", hi, 32'hFFFF_FFFF);
      chk("mult neg lo const", lo, 32'hFFFF_FFF1);
      run_md("multu", 3'd2, 32'hFFFF_FFFF, 32'd2);
      chk("multu hi const", hi, 32'h0000_0001);
      chk("multu lo const", lo, 32'hFFFF_FFFE);
      run_md("div neg", 3'd3, 32'hFFFF_FFF9, 32'd2);
      chk("div neg lo const", lo, 32'hFFFF_FFFD);
      chk("div neg hi const", hi, 32'hFFFF_FFFF);
      run_md("divu", 3'd4, 32'd7, 32'd2);
      chk("divu const", {hi[15:0], lo[15:0]}, 32'h0001_0003);

      run_mt("mthi", 3'd5, 32'h1234);
      run_mt("mtlo", 3'd6, 32'h5678);
      run_md("div by 0", 3'd3, 32'd7, 32'd0);
      chk("div0 hi const", hi, 32'h1234);
      chk("div0 lo const", lo, 32'h5678);
      run_md("divu by 0", 3'd4, 32'd9, 32'd0);
      run_md("div ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("ovf lo const", lo, 32'h8000_0000);
      chk("ovf hi const", hi, 32'd0);

      // mtlo held across a mult: ignored while busy, taken one edge after completion.
      op = 3'd1; a = 32'd6; b = 32'd7;
      @(negedge clk);
      op = 3'd6; a = 32'hAA;
      for (int i = 0; i < MC; i++) begin
         chk("held busy", {31'd0, busy}, 32'd1);
         chk("held lo hold", lo, lo_m);
         @(negedge clk);
      end
      chk("held busy end", {31'd0, busy}, 32'd0);
      chk("held hi prod", hi, 32'd0);
      chk("held lo prod", lo, 32'd42);
      @(negedge clk);
      op = 3'd0;
      hi_m = 32'd0; lo_m = 32'hAA;
      chk("held busy mtlo", {31'd0, busy}, 32'd0);
      chk("held hi final", hi, 32'd0);
      chk("held lo final", lo, 32'hAA);

      for (int i = 0; i < 24; i++) begin
         ro = 3'($urandom_range(1, 7));
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 3) == 0) rb = {28'd0, 4'($urandom)};
         if ($urandom_range(0, 5) == 0) ra = {31'd1, 1'b0} << 30;
         if (ro == 3'd7) begin
            op = 3'd7; a = ra; b = rb;
            @(negedge clk);
            op = 3'd0;
            chk("rsvd busy", {31'd0, busy}, 32'd0);
            chk("rsvd hi", hi, hi_m);
            chk("rsvd lo", lo, lo_m);
         end else if (ro >= 3'd5) run_mt("rnd mt", ro, ra);
         else run_md("rnd md", ro, ra, rb);
      end

      // Asynchronous reset in the middle of a divide.
      run_mt("pre mthi", 3'd5, 32'hDEAD_BEEF);
      op = 3'd3; a = 32'd100; b = 32'd7;
      @(negedge clk);
      op = 3'd0;
      @(negedge clk);
      @(negedge clk);
      chk("pre rst busy", {31'd0, busy}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("async busy", {31'd0, busy}, 32'd0);
      chk("async hi", hi, 32'd0);
      chk("async lo", lo, 32'd0);
      hi_m = 32'd0; lo_m = 32'd0;
      @(negedge clk);
      reset = 1'b0;
      repeat (DC + 3) @(negedge clk);
      chk("post rst busy", {31'd0, busy}, 32'd0);
      chk("post rst hi", hi, 32'd0);
      chk("post rst lo", lo, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
